// File: rtl/imem_pkg.sv
// Shared types, defaults and the physical-memory read port for the instruction-side responder.
// Latency: n/a (declarations only). Backpressure: n/a.
// pmem/pmem_read model the simulator's physical memory as sparse 64-bit doublewords.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam logic [63:0] IMEM_BASE_DEF = 64'h8000_0000;
    localparam logic [63:0] IMEM_SIZE_DEF = 64'h0800_0000;
    localparam logic [31:0] RESP_ERR_INST = 32'h0;

    // Doubleword-keyed backing store; keys are always 8-byte aligned.
    logic [63:0] pmem [logic [63:0]];

    function automatic void pmem_read(input logic [63:0] addr, output logic [63:0] rdata);
        if (pmem.exists(addr)) begin
            rdata = pmem[addr];
        end else begin
            rdata = 64'h0;
        end
    endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch-side request/response bundle between the fetch stage (master) and the memory responder (slave).
// Latency: n/a. Backpressure: valid/ready on both the request and the response channel.
interface imem_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/imem_addr_chk.sv
// Address legality check: out-of-window (and, with IMEM_ALIGN_CHECK_EN, misaligned) fetches fault.
// Latency: combinational. Backpressure: none.
module imem_addr_chk
    import imem_pkg::*;
#(
    parameter logic [63:0] MEM_BASE = IMEM_BASE_DEF,
    parameter logic [63:0] MEM_SIZE = IMEM_SIZE_DEF
) (
    input  logic [63:0] addr,
    output logic        err
);

    // One extra bit so a window ending at 2^64 does not wrap.
    logic [64:0] lim;
    logic        range_err;
    logic        align_err;

    assign lim       = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    assign range_err = (addr < MEM_BASE) || ({1'b0, addr} >= lim);

`ifdef IMEM_ALIGN_CHECK_EN
    assign align_err = (addr[1:0] != 2'b00);
`else
    assign align_err = 1'b0;
`endif

    assign err = range_err | align_err;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch memory responder: one outstanding request, word picked from a doubleword by addr[2].
// Latency: LATENCY edges from acceptance to resp_valid; optional IMEM_ALIGN_CHECK_EN faults misaligned pcs.
// Backpressure: response held stable until resp_ready; a new request is taken only in IDLE or on the response handshake.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned LATENCY  = 1,
    parameter logic [63:0] MEM_BASE = IMEM_BASE_DEF,
    parameter logic [63:0] MEM_SIZE = IMEM_SIZE_DEF
) (
    input logic   clk,
    input logic   reset,
    imem_if.slave bus
);

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    imem_state_e state;
    imem_state_e state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [63:0] addr_q;
    logic [63:0] rd_addr;
    logic [31:0] inst_q;
    logic        err_q;
    logic        rdy;
    logic        accept;
    logic        do_read;
    logic        rd_err;

    imem_addr_chk #(
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_addr_chk (
        .addr (rd_addr),
        .err  (rd_err)
    );

    // With LATENCY==1 the read happens at the acceptance edge, before addr_q is loaded.
    assign rd_addr = accept ? bus.req_addr : addr_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy       = 1'b0;
        do_read   = 1'b0;
        case (state)
            IDLE: rdy = 1'b1;
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    do_read   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rdy = bus.resp_ready;
                if (bus.resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        accept = bus.req_valid && rdy;
        if (accept) begin
            if (LATENCY == 1) begin
                do_read   = 1'b1;
                state_nxt = RESP;
            end else begin
                cnt_nxt   = CNT_INIT;
                state_nxt = WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= 64'h0;
            inst_q <= 32'h0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= bus.req_addr;
            end
            if (do_read) begin : rd
                logic [63:0] rd_dat;
                if (rd_err) begin
                    err_q  <= 1'b1;
                    inst_q <= RESP_ERR_INST;
                end else begin
                    pmem_read({rd_addr[63:3], 3'b000}, rd_dat);
                    err_q  <= 1'b0;
                    inst_q <= rd_addr[2] ? rd_dat[63:32] : rd_dat[31:0];
                end
            end
        end
    end

    assign bus.req_ready  = rdy;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_inst  = inst_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LATENCY 1, 3, 4) share one stimulus stream and are
// compared every cycle against a transaction-level model built from the fetch-window rules.
`timescale 1ns/1ps
module tb_imem_responder;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        resp_ready;
    logic [63:0] req_addr;

    always #5 clk = ~clk;

    imem_if b0 ();
    imem_if b1 ();
    imem_if b2 ();

    assign b0.req_valid = req_valid;  assign b0.req_addr = req_addr;  assign b0.resp_ready = resp_ready;
    assign b1.req_valid = req_valid;  assign b1.req_addr = req_addr;  assign b1.resp_ready = resp_ready;
    assign b2.req_valid = req_valid;  assign b2.req_addr = req_addr;  assign b2.resp_ready = resp_ready;

    imem_responder #(.LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b0));
    imem_responder #(.LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(b1));
    imem_responder #(.LATENCY(4)) u_l4 (.clk(clk), .reset(reset), .bus(b2));

    logic [2:0]  o_vld, o_rdy, o_err;
    logic [31:0] o_inst [3];

    assign o_vld  = {b2.resp_valid, b1.resp_valid, b0.resp_valid};
    assign o_rdy  = {b2.req_ready,  b1.req_ready,  b0.req_ready};
    assign o_err  = {b2.resp_err,   b1.resp_err,   b0.resp_err};
    assign o_inst[0] = b0.resp_inst;
    assign o_inst[1] = b1.resp_inst;
    assign o_inst[2] = b2.resp_inst;

    int vec  = 0;
    int miss = 0;

    // Reference: 32-bit words keyed by their byte address, plus per-instance outstanding request.
    logic [31:0] wmem [logic [63:0]];
    bit          m_out [3];
    bit          m_vld [3];
    bit          m_err [3];
    int          m_rem [3];
    logic [63:0] m_addr [3];
    logic [31:0] m_inst [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 4;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic put_word(input logic [63:0] a, input logic [31:0] w);
        logic [63:0] key;
        logic [63:0] dw;
        wmem[a] = w;
        key = a - (a % 8);
        dw  = pmem.exists(key) ? pmem[key] : 64'h0;
        if (a % 8 == 4) dw[63:32] = w;
        else            dw[31:0]  = w;
        pmem[key] = dw;
    endtask

    task automatic model_read(input logic [63:0] a, output bit err, output logic [31:0] inst);
        logic [63:0] wa;
        err = (a < 64'h8000_0000) || (a >= 64'h8800_0000);
`ifdef IMEM_ALIGN_CHECK_EN
        if (a % 4 != 0) err = 1'b1;
`endif
        inst = 32'h0;
        if (!err) begin
            wa   = a - (a % 4);
            inst = wmem.exists(wa) ? wmem[wa] : 32'h0;
        end
    endtask

    task automatic finish_read(input int d);
        model_read(m_addr[d], m_err[d], m_inst[d]);
        m_vld[d] = 1'b1;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            bit can_take;
            if (reset) begin
                m_out[d] = 1'b0;
                m_vld[d] = 1'b0;
            end else begin
                can_take = !m_out[d] || (m_vld[d] && resp_ready);
                if (m_vld[d] && resp_ready) begin
                    m_out[d] = 1'b0;
                    m_vld[d] = 1'b0;
                end else if (m_out[d] && !m_vld[d]) begin
                    m_rem[d]--;
                    if (m_rem[d] == 0) finish_read(d);
                end
                if (req_valid && can_take) begin
                    m_out[d]  = 1'b1;
                    m_addr[d] = req_addr;
                    m_rem[d]  = lat_of(d) - 1;
                    if (m_rem[d] == 0) finish_read(d);
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            check($sformatf("vld_l%0d", lat_of(d)), o_vld[d], m_vld[d]);
            check($sformatf("rdy_l%0d", lat_of(d)), o_rdy[d], !m_out[d] || (m_vld[d] && resp_ready));
            if (m_vld[d]) begin
                check($sformatf("inst_l%0d", lat_of(d)), o_inst[d], m_inst[d]);
                check($sformatf("err_l%0d", lat_of(d)), o_err[d], m_err[d]);
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic rv, input logic [63:0] a, input logic rr);
        reset = rst; req_valid = rv; req_addr = a; resp_ready = rr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [63:0] pick_addr();
        int unsigned r = $urandom_range(0, 15);
        logic [63:0] a;
        if (r < 10) begin
            a = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 64'd4;
            if (r == 0) a = a + 64'($urandom_range(1, 3));
        end else begin
            case (r)
                10:      a = 64'h7FFF_FFFC;
                11:      a = 64'h8800_0000;
                12:      a = 64'h87FF_FFFC;
                13:      a = 64'h8800_0004;
                14:      a = 64'h0;
                default: a = 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
        end
        return a;
    endfunction

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = 64'h0; resp_ready = 1'b1;

        put_word(64'h8000_0000, 32'h0000_0413);
        put_word(64'h8000_0004, 32'h0010_0093);
        put_word(64'h8000_0008, 32'h0020_8133);
        for (int i = 3; i < 16; i++) put_word(64'h8000_0000 + 64'(i * 4), $urandom);
        put_word(64'h87FF_FFFC, 32'h1234_5678);
        // Data just outside the window: a read that slips past the range check becomes visible.
        put_word(64'h7FFF_FFF8, 32'hDEAD_BEEF);
        put_word(64'h7FFF_FFFC, 32'hCAFE_F00D);
        put_word(64'h8800_0000, 32'hBAD0_0001);
        put_word(64'h8800_0004, 32'hBAD0_0002);

        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_inst_l%0d", lat_of(d)), o_inst[d], 32'h0);
            check($sformatf("rst_err_l%0d", lat_of(d)), o_err[d], 1'b0);
        end
        check("rst_rdy", o_rdy, 3'b111);

        cyc(0, 1, 64'h8000_0000, 1);
        check("l1_vld", o_vld[0], 1'b1);
        check("l1_inst", o_inst[0], 32'h0000_0413);
        check("l1_err", o_err[0], 1'b0);
        check("l3_wait_rdy", o_rdy[1], 1'b0);
        repeat (4) cyc(0, 0, 0, 1);

        cyc(0, 1, 64'h8000_0004, 1);
        cyc(0, 0, 0, 1);
        check("l3_early", o_vld[1], 1'b0);
        cyc(0, 0, 0, 1);
        check("l3_vld", o_vld[1], 1'b1);
        check("l3_inst", o_inst[1], 32'h0010_0093);
        repeat (3) cyc(0, 0, 0, 1);

        cyc(0, 1, 64'h8000_0000, 0);
        repeat (5) cyc(0, 0, 0, 0);
        check("bp_rdy", o_rdy, 3'b000);
        check("bp_inst", o_inst[0], 32'h0000_0413);
        cyc(0, 1, 64'h8000_0008, 1);
        check("b2b_vld", o_vld[0], 1'b1);
        check("b2b_inst", o_inst[0], 32'h0020_8133);
        repeat (4) cyc(0, 0, 0, 1);

        cyc(0, 1, 64'h7FFF_FFFC, 1);
        check("lo_err", o_err[0], 1'b1);
        check("lo_inst", o_inst[0], 32'h0);
        repeat (4) cyc(0, 0, 0, 1);
        cyc(0, 1, 64'h8800_0000, 1);
        check("hi_err", o_err[0], 1'b1);
        check("hi_inst", o_inst[0], 32'h0);
        repeat (4) cyc(0, 0, 0, 1);

        cyc(0, 1, 64'h8000_0004, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check("rstw_vld", o_vld[2], 1'b0);
        check("rstw_rdy", o_rdy[2], 1'b1);
        repeat (6) cyc(0, 0, 0, 1);

        cyc(0, 1, 64'h8000_0002, 1);
`ifdef IMEM_ALIGN_CHECK_EN
        check("ua_err", o_err[0], 1'b1);
        check("ua_inst", o_inst[0], 32'h0);
`else
        check("ua_err", o_err[0], 1'b0);
        check("ua_inst", o_inst[0], 32'h0000_0413);
`endif
        repeat (4) cyc(0, 0, 0, 1);

        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, pick_addr(),
                $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
